// File: rtl/uart_tx_core.sv
// uart_tx_core
// Serializes one parallel word per accepted request into a UART frame:
// start(0), data LSB-first, optional parity, stop(1). Each bit is held for
// the latched prescale count of clk cycles. All outputs come from flops.
module uart_tx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      tx_done
);

    // Bit index width; a 1-bit payload still needs a 1-bit index.
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]          BIT_ONE  = BIT_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                      state_q,   state_d;
    logic [DATA_WIDTH-1:0]       data_q,    data_d;
    logic                        par_en_q,  par_en_d;
    logic                        par_typ_q, par_typ_d;
    logic [PRESCALE_WIDTH-1:0]   ps_q,      ps_d;
    logic [PRESCALE_WIDTH-1:0]   cnt_q,     cnt_d;
    logic [BIT_W-1:0]            bit_q,     bit_d;
    logic                        tx_q,      tx_d;
    logic                        busy_q,    busy_d;
    logic                        done_q,    done_d;

    // Helpers derived from the latched frame configuration.
    logic                        bit_end;
    logic                        parity_bit;
    logic [BIT_W-1:0]            bit_nxt;
    logic [PRESCALE_WIDTH-1:0]   ps_in;

    // A prescale of zero would never let a bit finish, so it behaves as one.
    assign ps_in      = (prescale == '0) ? PS_ONE : prescale;
    // Last cycle of the current bit period.
    assign bit_end    = (cnt_q == (ps_q - PS_ONE));
    // Even parity is the XOR of the data; odd parity is its complement.
    assign parity_bit = (^data_q) ^ par_typ_q;
    assign bit_nxt    = bit_q + BIT_ONE;

    // Next-state, counters and registered-output values for every state.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        ps_d      = ps_q;
        cnt_d     = bit_end ? '0 : (cnt_q + PS_ONE);
        bit_d     = bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    // Snapshot the whole frame configuration so later input
                    // changes only affect the next accepted frame.
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    ps_d      = ps_in;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                // Illegal encoding: recover to an idle line.
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset forces an idle-high line at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            ps_q      <= PS_ONE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            ps_q      <= ps_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed testbench for uart_tx_core. Inputs change and outputs are
// sampled on the falling clock edge; expected line sequences are written
// out by hand, first transmitted bit in the MSB of each constant.
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;
    logic       tx_done;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rstn = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: TX_OUT=%b busy=%b tx_done=%b, required 1 0 0", TX_OUT, busy, tx_done);
        end
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_reset cyc %0d: TX_OUT=%b busy=%b tx_done=%b, required 1 0 0", c, TX_OUT, busy, tx_done);
            end
        end
        $display("test_reset done");
    endtask

    // ps=8, 0xA5, even parity.
    task automatic test_parity_even();
        logic [10:0] seq = 11'b01010010101;
        int len = 11;
        int ps  = 8;
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 6'd8; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int c = 0; c < len * ps; c++) begin
            n_vec++;
            if (TX_OUT !== seq[len - 1 - c / ps] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL par_even cyc %0d: TX_OUT=%b busy=%b, required TX_OUT=%b busy=1", c, TX_OUT, busy, seq[len - 1 - c / ps]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL par_even_end: TX_OUT=%b busy=%b tx_done=%b, required 1 0 1", TX_OUT, busy, tx_done);
        end
        @(negedge clk);
        n_vec++;
        if (tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL par_even_done_pulse: tx_done=%b, required 0", tx_done);
        end
        $display("test_parity_even: 0xA5 ps=8 frame of 88 cycles checked");
    endtask

    // ps=4, odd parity on 0x00 (parity 1) and 0x01 (parity 0).
    task automatic test_parity_odd();
        logic [7:0]  dat  [2] = '{8'h00, 8'h01};
        logic [10:0] seqs [2] = '{11'b00000000011, 11'b01000000001};
        int len = 11;
        int ps  = 4;
        for (int f = 0; f < 2; f++) begin
            P_DATA = dat[f]; PAR_EN = 1'b1; PAR_TYP = 1'b1; prescale = 6'd4; Data_Valid = 1'b1;
            @(negedge clk);
            Data_Valid = 1'b0;
            for (int c = 0; c < len * ps; c++) begin
                n_vec++;
                if (TX_OUT !== seqs[f][len - 1 - c / ps] || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL par_odd f%0d cyc %0d: TX_OUT=%b busy=%b, required TX_OUT=%b busy=1", f, c, TX_OUT, busy, seqs[f][len - 1 - c / ps]);
                end
                @(negedge clk);
            end
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
                n_err++;
                $display("FAIL par_odd_end f%0d: TX_OUT=%b busy=%b tx_done=%b, required 1 0 1", f, TX_OUT, busy, tx_done);
            end
            @(negedge clk);
            $display("test_parity_odd: frame %0d data=%h ps=4 checked", f, dat[f]);
        end
    endtask

    // ps=1 and ps=0 must give the same one-clock-per-bit frame for 0xFF.
    task automatic test_prescale_one();
        logic [5:0]  psv [2] = '{6'd1, 6'd0};
        logic [10:0] seq = 11'b00111111111;
        int len = 10;
        for (int f = 0; f < 2; f++) begin
            P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = psv[f]; Data_Valid = 1'b1;
            @(negedge clk);
            Data_Valid = 1'b0;
            for (int c = 0; c < len; c++) begin
                n_vec++;
                if (TX_OUT !== seq[len - 1 - c] || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL ps_one prescale=%0d cyc %0d: TX_OUT=%b busy=%b, required TX_OUT=%b busy=1", psv[f], c, TX_OUT, busy, seq[len - 1 - c]);
                end
                @(negedge clk);
            end
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
                n_err++;
                $display("FAIL ps_one_end prescale=%0d: TX_OUT=%b busy=%b tx_done=%b, required 1 0 1", psv[f], TX_OUT, busy, tx_done);
            end
            @(negedge clk);
            $display("test_prescale_one: prescale=%0d frame checked", psv[f]);
        end
    endtask

    // Data_Valid held high across two frames; a pulse during frame 2 is ignored.
    task automatic test_back_to_back();
        logic [10:0] seqs [2] = '{11'b00001111001, 11'b00110000111};
        int len = 10;
        int ps  = 2;
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd2; Data_Valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < len * ps; c++) begin
                if (f == 0 && c == 10) P_DATA = 8'hC3;
                if (f == 1 && c == 0)  Data_Valid = 1'b0;
                if (f == 1 && c == 5)  Data_Valid = 1'b1;
                if (f == 1 && c == 7)  Data_Valid = 1'b0;
                n_vec++;
                if (TX_OUT !== seqs[f][len - 1 - c / ps] || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b f%0d cyc %0d: TX_OUT=%b busy=%b, required TX_OUT=%b busy=1", f, c, TX_OUT, busy, seqs[f][len - 1 - c / ps]);
                end
                @(negedge clk);
            end
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_gap f%0d: TX_OUT=%b busy=%b tx_done=%b, required 1 0 1", f, TX_OUT, busy, tx_done);
            end
            @(negedge clk);
            $display("test_back_to_back: frame %0d checked", f);
        end
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_no_extra cyc %0d: TX_OUT=%b busy=%b tx_done=%b, required 1 0 0", c, TX_OUT, busy, tx_done);
            end
            @(negedge clk);
        end
    endtask

    // Inputs changed mid-frame only affect the following frame.
    task automatic test_latched_inputs();
        logic [10:0] seqs [2] = '{11'b01010010101, 11'b00000000001};
        int lens [2] = '{11, 10};
        int pss  [2] = '{3, 7};
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 6'd3; Data_Valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            Data_Valid = 1'b0;
            for (int c = 0; c < lens[f] * pss[f]; c++) begin
                if (f == 0 && c == 1) begin
                    P_DATA = 8'h00; prescale = 6'd7; PAR_TYP = 1'b1; PAR_EN = 1'b0;
                end
                n_vec++;
                if (TX_OUT !== seqs[f][lens[f] - 1 - c / pss[f]] || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL latched f%0d cyc %0d: TX_OUT=%b busy=%b, required TX_OUT=%b busy=1", f, c, TX_OUT, busy, seqs[f][lens[f] - 1 - c / pss[f]]);
                end
                @(negedge clk);
            end
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
                n_err++;
                $display("FAIL latched_end f%0d: TX_OUT=%b busy=%b tx_done=%b, required 1 0 1", f, TX_OUT, busy, tx_done);
            end
            Data_Valid = 1'b1;
            $display("test_latched_inputs: frame %0d ps=%0d checked", f, pss[f]);
        end
        Data_Valid = 1'b0;
        @(negedge clk);
    endtask

    // Reset during DATA bit 3, then a full frame after release.
    task automatic test_reset_mid_frame();
        logic [10:0] seq = 11'b00101101011;
        int len = 11;
        int ps  = 2;
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd4; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (17) @(negedge clk);
        n_vec++;
        if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: TX_OUT=%b busy=%b, required 0 1", TX_OUT, busy);
        end
        #2 rstn = 1'b0;
        #1;
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: TX_OUT=%b busy=%b tx_done=%b, required 1 0 0", TX_OUT, busy, tx_done);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1; prescale = 6'd2; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int c = 0; c < len * ps; c++) begin
            n_vec++;
            if (TX_OUT !== seq[len - 1 - c / ps] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL rst_mid_after cyc %0d: TX_OUT=%b busy=%b, required TX_OUT=%b busy=1", c, TX_OUT, busy, seq[len - 1 - c / ps]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_after_end: TX_OUT=%b busy=%b tx_done=%b, required 1 0 1", TX_OUT, busy, tx_done);
        end
        @(negedge clk);
        $display("test_reset_mid_frame: abort and recovery frame 0x5A checked");
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_parity_odd();
        test_prescale_one();
        test_back_to_back();
        test_latched_inputs();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
